// File: rtl/dma_copy.sv
`timescale 1ns/1ps
// dma_copy: word-granular memory-to-memory copy engine.
// A register port (SRC/DST/CNT/CTRL) configures the copy. A second bus
// initiator port moves one word per read/write pair, leaving an idle cycle
// between bus cycles. An interrupt is raised on completion when enabled.
module dma_copy #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq,
    output logic        m_stb,
    output logic        m_we,
    output logic [29:0] m_addr,
    input  logic [31:0] m_din,
    output logic [31:0] m_dout,
    input  logic        m_ack
);

    // GAP_W / GAP_R are the mandatory idle cycles between bus cycles.
    typedef enum logic [2:0] {IDLE, RD, GAP_W, WR, GAP_R} state_t;

    state_t            state, state_nxt;
    logic [29:0]       src, dst;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       buffer;
    logic              ien, done, abort_pend, irq_q;

    logic busy, reg_wr, wr_src, wr_dst, wr_cnt, wr_ctrl;
    logic start_go, start_nil, abort_req, abort_hit;
    logic last_word, rd_ack, wr_ack, complete;

    assign busy      = (state != IDLE);
    assign reg_wr    = stb & we;
    // Address/count registers are frozen while a copy is running.
    assign wr_src    = reg_wr && (addr == 2'd0) && !busy;
    assign wr_dst    = reg_wr && (addr == 2'd1) && !busy;
    assign wr_cnt    = reg_wr && (addr == 2'd2) && !busy;
    assign wr_ctrl   = reg_wr && (addr == 2'd3);
    assign start_go  = wr_ctrl && data_in[0] && !busy && (cnt != '0);
    assign start_nil = wr_ctrl && data_in[0] && !busy && (cnt == '0);
    assign abort_req = wr_ctrl && data_in[3] && busy;
    assign abort_hit = abort_pend || abort_req;
    assign last_word = (cnt == CNT_W'(1));
    assign rd_ack    = (state == RD) && m_ack;
    assign wr_ack    = (state == WR) && m_ack;
    // Finishing the last word wins over a concurrent abort.
    assign complete  = wr_ack && last_word;

    assign ack = stb;
    assign irq = irq_q;

    // Register read mux, zero when not selected.
    always_comb begin
        data_out = '0;
        if (stb) begin
            case (addr)
                2'd0:    data_out = {src, 2'b00};
                2'd1:    data_out = {dst, 2'b00};
                2'd2:    data_out = 32'(cnt);
                default: data_out = {29'd0, done, ien, busy};
            endcase
        end
    end

    // FSM state register; reset drops m_stb at once since outputs decode state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and initiator outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        m_stb     = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_dout    = '0;
        case (state)
            IDLE: begin
                if (start_go) state_nxt = RD;
            end
            RD: begin
                m_stb  = 1'b1;
                m_addr = src;
                if (m_ack) state_nxt = abort_hit ? IDLE : GAP_W;
            end
            GAP_W: begin
                state_nxt = abort_hit ? IDLE : WR;
            end
            WR: begin
                m_stb  = 1'b1;
                m_we   = 1'b1;
                m_addr = dst;
                m_dout = buffer;
                if (m_ack) state_nxt = (last_word || abort_hit) ? IDLE : GAP_R;
            end
            GAP_R: begin
                state_nxt = abort_hit ? IDLE : RD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register file, word buffer and status/interrupt flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src        <= '0;
            dst        <= '0;
            cnt        <= '0;
            buffer     <= '0;
            ien        <= 1'b0;
            done       <= 1'b0;
            abort_pend <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_src)      src <= data_in[31:2];
            else if (rd_ack) src <= src + 30'd1;

            if (wr_dst)      dst <= data_in[31:2];
            else if (wr_ack) dst <= dst + 30'd1;

            if (wr_cnt)      cnt <= data_in[CNT_W-1:0];
            else if (wr_ack) cnt <= cnt - CNT_W'(1);

            if (rd_ack) buffer <= m_din;

            if (wr_ctrl) ien <= data_in[1];

            // DONE: set on completion or empty start, cleared by start or write-0.
            if (complete || start_nil)          done <= 1'b1;
            else if (start_go)                  done <= 1'b0;
            else if (wr_ctrl && !data_in[2])    done <= 1'b0;

            if (state_nxt == IDLE) abort_pend <= 1'b0;
            else if (abort_req)    abort_pend <= 1'b1;

            irq_q <= done & ien;
        end
    end

endmodule
